ftdi_stream_bridge: RTL and testbench
=====================================

FTDI_STREAM_BRIDGE -- requirements
Module: ftdi_stream_bridge

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, log2 of entries in each FIFO (RX and TX, 16 bytes each by default).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clock_in  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  byte from FTDI interface, valid while rx_rq high.
REQ-006 rx_rq  in  1  FTDI interface byte-available request.
REQ-007 rx_st  out  1  acknowledge to FTDI interface; high = byte taken.
REQ-008 tx_data  out  8  byte to FTDI interface, stable while tx_rq high.
REQ-009 tx_rq  out  1  request to FTDI interface to send tx_data.
REQ-010 tx_st  in  1  FTDI interface strobe; rising edge = tx_data captured.
REQ-011 m_data, m_valid, m_ready  out 8 / out 1 / in 1  received-byte stream to user logic.
REQ-012 s_data, s_valid, s_ready  in 8 / in 1 / out 1  transmit-byte stream from user logic.
REQ-013 rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy.

Function
REQ-014 rx_rq and tx_st SHALL be registered once (rx_rq_r, tx_st_r) before any FSM use; tx_st_r SHALL have a delayed copy for rising-edge detect.
REQ-015 RX FSM states: R_IDLE, R_ACK.
REQ-016 R_IDLE: if rx_rq_r=1 and RX FIFO not full -> write rx_data, rx_st<=1, go R_ACK; if full -> stay, rx_st=0 (backpressure).
REQ-017 R_ACK: when rx_rq_r=0 -> rx_st<=0, go R_IDLE; otherwise hold rx_st=1.
REQ-018 rx_st SHALL rise 2 cycles after rx_rq rises when FIFO not full; exactly one FIFO write per rx_rq pulse.
REQ-019 m_valid = RX FIFO not empty; m_data = FIFO head (registered/first-word-fall-through); pop when m_valid&m_ready.
REQ-020 Written byte SHALL appear on m_valid no earlier than 1 cycle after the write.
REQ-021 s_ready = TX FIFO not full; push when s_valid&s_ready.
REQ-022 TX FSM states: T_IDLE, T_REQ, T_WAIT.
REQ-023 T_IDLE: if TX FIFO not empty -> tx_data<=head, pop, tx_rq<=1, go T_REQ.
REQ-024 T_REQ: on tx_st_r rising edge -> tx_rq<=0, go T_WAIT; tx_data SHALL not change in T_REQ.
REQ-025 T_WAIT: when tx_st_r=0 -> go T_IDLE.
REQ-026 Simultaneous push and pop on either FIFO: both occur, level unchanged; at full, push is refused (flag from current cycle); at empty, pop is refused.
REQ-027 Pointers wrap modulo 2^DEPTH_LOG2; rx_level ranges 0..2^DEPTH_LOG2.
REQ-028 RX and TX paths SHALL operate concurrently and independently.

Reset
REQ-029 On reset: both FSMs to idle, rx_st=0, tx_rq=0, tx_data=0, FIFOs emptied (rx_level=0, m_valid=0, s_ready=1), registered inputs cleared.
REQ-030 Reset mid-handshake SHALL abort it: in-flight byte discarded, no further rx_st/tx_rq until new request after reset release.

Configuration
REQ-031 Macro FTDI_LOOPBACK_EN: when defined, RX FIFO output SHALL feed TX FIFO input internally (pop when TX not full); m_valid forced 0, s_ready forced 0, m_ready/s_data/s_valid ignored.
REQ-032 Without FTDI_LOOPBACK_EN: RX and TX streams independent as in REQ-019..REQ-025.

Verification
REQ-033 Reset, rx_rq pulse with rx_data=0x55, m_ready=1 -> rx_st high 2 cycles later, drops 1 cycle after rx_rq_r low; m_data=0x55 with m_valid for one cycle.
REQ-034 m_ready=0, 17 RX bytes 0x00..0x10 (DEPTH_LOG2=4) -> rx_level=16, 17th rx_rq left unacknowledged; after one pop, 17th accepted, bytes read back in order 0x00..0x10.
REQ-035 s_data 0xA1,0xA2,0xA3 back-to-back, tx_st pulsed 1 cycle per tx_rq -> three tx_rq cycles, tx_data 0xA1,0xA2,0xA3 in order, tx_rq low after each tx_st edge.
REQ-036 Concurrent RX byte 0x3C and TX byte 0xC3 -> both handshakes complete; m_data=0x3C, tx_data=0xC3.
REQ-037 Reset asserted while rx_st=1 and tx_rq=1 -> next cycle rx_st=0, tx_rq=0, rx_level=0, s_ready=1.
REQ-038 FTDI_LOOPBACK_EN defined, RX bytes 0x10,0x20 -> tx_data emits 0x10 then 0x20; m_valid stays 0.

Source files
------------

// File: rtl/ftdi_stream_bridge.sv
// ftdi_stream_bridge
//   Bridges a request/strobe style FTDI byte interface to a pair of
//   valid/ready byte streams through two small FIFOs (RX and TX).
//
//   RX path: FTDI rx_rq/rx_data/rx_st -> RX FIFO -> m_data/m_valid/m_ready
//   TX path: s_data/s_valid/s_ready -> TX FIFO -> FTDI tx_rq/tx_data/tx_st
//
// Ports
//   clock_in            system clock, all logic on its rising edge
//   reset               synchronous, active-high reset
//   rx_data/rx_rq/rx_st FTDI receive byte, request, acknowledge
//   tx_data/tx_rq/tx_st FTDI transmit byte, request, capture strobe
//   m_data/m_valid/m_ready  received byte stream to user logic
//   s_data/s_valid/s_ready  transmit byte stream from user logic
//   rx_level            RX FIFO occupancy (0 .. 2**DEPTH_LOG2)
//
// Parameters
//   DEPTH_LOG2          log2 of the entry count of each FIFO
//
// Build option
//   FTDI_LOOPBACK_EN    when defined, the RX FIFO output feeds the TX FIFO
//                       input internally; the user streams are disabled
//                       (m_valid=0, s_ready=0, m_ready/s_data/s_valid ignored).

module ftdi_stream_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rq,
  output logic                  rx_st,
  output logic [7:0]            tx_data,
  output logic                  tx_rq,
  input  logic                  tx_st,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DEPTH_LOG2:0]   rx_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] PTR_ONE    = (DEPTH_LOG2+1)'(1);
  localparam int RXF = 0;
  localparam int TXF = 1;

  // FIFO control, index RXF = receive FIFO, TXF = transmit FIFO
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] full;
  logic [1:0] empty;
  logic [7:0] wdata [2];
  logic [7:0] head  [2];

  // Asynchronous FTDI handshake inputs are registered once; tx_st gets a
  // second stage so its rising edge can be detected.
  logic rx_rq_q;
  logic tx_st_q;
  logic tx_st_qq;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      rx_rq_q  <= 1'b0;
      tx_st_q  <= 1'b0;
      tx_st_qq <= 1'b0;
    end else begin
      rx_rq_q  <= rx_rq;
      tx_st_q  <= tx_st;
      tx_st_qq <= tx_st_q;
    end
  end

  // Two identical FIFOs. Pointers carry one extra wrap bit so that
  // wr - rd gives the occupancy directly (0 .. DEPTH). The head is read
  // combinationally so the oldest byte falls through to the output.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [7:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q;
    logic [DEPTH_LOG2:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    assign full[gi]  = (wr_ptr_q - rd_ptr_q) == FULL_LEVEL;
    assign empty[gi] = (wr_ptr_q == rd_ptr_q);
    // Full/empty come from the current occupancy, so a push at full is
    // refused even when a pop happens in the same cycle.
    assign do_push   = push[gi] & ~full[gi];
    assign do_pop    = pop[gi]  & ~empty[gi];
    assign head[gi]  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clock_in) begin
      if (do_push) begin
        mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata[gi];
      end
    end

    always_ff @(posedge clock_in) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end

    if (gi == RXF) begin : g_level
      assign rx_level = wr_ptr_q - rd_ptr_q;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic {R_IDLE, R_ACK} rx_state_e;
  rx_state_e rx_state_q, rx_state_d;
  logic      rx_st_q, rx_st_d;
  logic      rx_push;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_st_d    = rx_st_q;
    rx_push    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        // A full FIFO leaves the request unacknowledged (backpressure).
        if (rx_rq_q && !full[RXF]) begin
          rx_push    = 1'b1;
          rx_st_d    = 1'b1;
          rx_state_d = R_ACK;
        end else begin
          rx_st_d = 1'b0;
        end
      end
      R_ACK: begin
        // Stay here until the request is withdrawn: one write per pulse.
        if (!rx_rq_q) begin
          rx_st_d    = 1'b0;
          rx_state_d = R_IDLE;
        end else begin
          rx_st_d = 1'b1;
        end
      end
      default: begin
        rx_st_d    = 1'b0;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- TX FSM
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT} tx_state_e;
  tx_state_e  tx_state_q, tx_state_d;
  logic       tx_rq_q, tx_rq_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_pop;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_rq_d    = tx_rq_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!empty[TXF]) begin
          tx_data_d  = head[TXF];
          tx_pop     = 1'b1;
          tx_rq_d    = 1'b1;
          tx_state_d = T_REQ;
        end
      end
      T_REQ: begin
        // tx_data is held here; only a rising strobe releases the request.
        if (tx_st_q && !tx_st_qq) begin
          tx_rq_d    = 1'b0;
          tx_state_d = T_WAIT;
        end
      end
      T_WAIT: begin
        if (!tx_st_q) tx_state_d = T_IDLE;
      end
      default: begin
        tx_rq_d    = 1'b0;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      rx_st_q    <= 1'b0;
      tx_state_q <= T_IDLE;
      tx_rq_q    <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_st_q    <= rx_st_d;
      tx_state_q <= tx_state_d;
      tx_rq_q    <= tx_rq_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign push[RXF]  = rx_push;
  assign wdata[RXF] = rx_data;
  assign pop[TXF]   = tx_pop;

`ifdef FTDI_LOOPBACK_EN
  // Received bytes move straight into the TX FIFO whenever it has room.
  logic unused_user_inputs;
  assign unused_user_inputs = ^{m_ready, s_valid, s_data};
  assign pop[RXF]   = !empty[RXF] && !full[TXF];
  assign push[TXF]  = !empty[RXF] && !full[TXF];
  assign wdata[TXF] = head[RXF];
  assign m_valid    = 1'b0;
  assign s_ready    = 1'b0;
`else
  assign pop[RXF]   = !empty[RXF] && m_ready;
  assign push[TXF]  = s_valid && !full[TXF];
  assign wdata[TXF] = s_data;
  assign m_valid    = !empty[RXF];
  assign s_ready    = !full[TXF];
`endif

  assign m_data  = head[RXF];
  assign rx_st   = rx_st_q;
  assign tx_rq   = tx_rq_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_ftdi_stream_bridge.sv
// tb_ftdi_stream_bridge
//   Self-checking bench for ftdi_stream_bridge (DEPTH_LOG2 = 4).
//   Directed handshake sequences, a table-driven RX fill/backpressure test,
//   and a randomized phase checked against queue-based reference models of
//   the two FIFOs. With FTDI_LOOPBACK_EN defined only the loopback
//   sequence runs.

module tb_ftdi_stream_bridge;

  localparam int DL2 = 4;

  logic           clock_in = 1'b0;
  logic           reset;
  logic [7:0]     rx_data;
  logic           rx_rq;
  logic           rx_st;
  logic [7:0]     tx_data;
  logic           tx_rq;
  logic           tx_st;
  logic [7:0]     m_data;
  logic           m_valid;
  logic           m_ready;
  logic [7:0]     s_data;
  logic           s_valid;
  logic           s_ready;
  logic [DL2:0]   rx_level;

  ftdi_stream_bridge #(.DEPTH_LOG2(DL2)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_rq    (rx_rq),
    .rx_st    (rx_st),
    .tx_data  (tx_data),
    .tx_rq    (tx_rq),
    .tx_st    (tx_st),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .rx_level (rx_level)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    bit         exp_ack;
    logic [4:0] exp_level;
  } fill_vec_t;
  fill_vec_t fill_tbl [17];

  // reference models for the randomized phase
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  int         rx_phase;
  int         rx_wait;
  logic       prev_tx_rq;
  logic [7:0] prev_tx_data;
  bit         tx_pulsed;
  int         st_hold;
  int         tx_wd;
  bit         gen;
  bit         ack;
  bit         a36;
  logic [7:0] exp_tx [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  // Present a byte and wait (bounded) for rx_st; on acceptance withdraw the
  // request and wait for the acknowledge to drop. Unacknowledged requests
  // are left asserted.
  task automatic rx_send(input logic [7:0] b, input int budget, output bit acked);
    rx_data = b;
    rx_rq   = 1'b1;
    acked   = 1'b0;
    for (int i = 0; i < budget && !acked; i++) begin
      step();
      if (rx_st === 1'b1) acked = 1'b1;
    end
    if (acked) begin
      rx_rq = 1'b0;
      for (int i = 0; i < 6 && rx_st !== 1'b0; i++) step();
      check("rx_st_release", rx_st, 1'b0);
    end
  endtask

  task automatic wait_tx_rq(input logic val, input int budget, input string name);
    for (int i = 0; i < budget && tx_rq !== val; i++) step();
    check(name, tx_rq, val);
  endtask

  task automatic wait_rx_st(input logic val, input int budget, input string name);
    for (int i = 0; i < budget && rx_st !== val; i++) step();
    check(name, rx_st, val);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 17; i++) begin
      fill_tbl[i].data      = 8'(i);
      fill_tbl[i].exp_ack   = (i < 16);
      fill_tbl[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
    end
    exp_tx[0] = 8'hA1; exp_tx[1] = 8'hA2; exp_tx[2] = 8'hA3;

    reset = 1'b1; rx_data = 8'h00; rx_rq = 1'b0; tx_st = 1'b0;
    m_ready = 1'b0; s_data = 8'h00; s_valid = 1'b0;
    repeat (3) step();
    check("rst_rx_st", rx_st, 1'b0);
    check("rst_tx_rq", tx_rq, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rx_level", rx_level, 5'd0);
    check("rst_m_valid", m_valid, 1'b0);
    reset = 1'b0;
    step();

`ifdef FTDI_LOOPBACK_EN
    check("lb_s_ready", s_ready, 1'b0);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
    rx_send(8'h10, 10, ack); check("lb_ack0", ack, 1'b1);
    check("lb_m_valid0", m_valid, 1'b0);
    rx_send(8'h20, 10, ack); check("lb_ack1", ack, 1'b1);
    for (int j = 0; j < 2; j++) begin
      wait_tx_rq(1'b1, 10, "lb_tx_rq");
      check("lb_tx_data", tx_data, (j == 0) ? 8'h10 : 8'h20);
      check("lb_m_valid", m_valid, 1'b0);
      check("lb_s_ready", s_ready, 1'b0);
      tx_st = 1'b1; step(); tx_st = 1'b0;
      wait_tx_rq(1'b0, 4, "lb_tx_release");
    end
    repeat (10) step();
    check("lb_tx_idle", tx_rq, 1'b0);
    check("lb_rx_level", rx_level, 5'd0);
    s_valid = 1'b0;
`else
    check("rst_s_ready", s_ready, 1'b1);

    // single RX byte: ack timing and one-cycle stream presentation
    m_ready = 1'b1; rx_data = 8'h55; rx_rq = 1'b1;
    step(); check("r33_st_c1", rx_st, 1'b0);
    step(); check("r33_st_c2", rx_st, 1'b1);
    check("r33_m_valid", m_valid, 1'b1);
    check("r33_m_data", m_data, 8'h55);
    rx_rq = 1'b0;
    step(); check("r33_st_hold", rx_st, 1'b1);
    check("r33_m_valid_gone", m_valid, 1'b0);
    step(); check("r33_st_drop", rx_st, 1'b0);
    m_ready = 1'b0;

    // fill to full, 17th byte backpressured
    for (int i = 0; i < 17; i++) begin
      rx_send(fill_tbl[i].data, 10, ack);
      check("fill_ack", ack, fill_tbl[i].exp_ack);
      check("fill_level", rx_level, fill_tbl[i].exp_level);
    end
    check("fill_st_low", rx_st, 1'b0);
    check("fill_head_valid", m_valid, 1'b1);
    check("fill_head", m_data, 8'h00);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("fill_level_pop", rx_level, 5'd15);
    wait_rx_st(1'b1, 4, "fill_17th_ack");
    rx_rq = 1'b0;
    wait_rx_st(1'b0, 4, "fill_17th_release");
    check("fill_level_refill", rx_level, 5'd16);
    m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("fill_rd_valid", m_valid, 1'b1);
      check("fill_rd_data", m_data, 8'(k));
      step();
    end
    m_ready = 1'b0;
    check("fill_empty", m_valid, 1'b0);
    check("fill_level_0", rx_level, 5'd0);

    // three back-to-back TX bytes
    s_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      s_data = exp_tx[j];
      check("tx_s_ready", s_ready, 1'b1);
      step();
    end
    s_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wait_tx_rq(1'b1, 8, "tx_rq_rise");
      check("tx_data_seq", tx_data, exp_tx[j]);
      repeat (2) begin
        step();
        check("tx_rq_held", tx_rq, 1'b1);
        check("tx_data_held", tx_data, exp_tx[j]);
      end
      tx_st = 1'b1; step(); tx_st = 1'b0;
      wait_tx_rq(1'b0, 4, "tx_rq_release");
    end
    repeat (10) step();
    check("tx_no_extra_rq", tx_rq, 1'b0);

    // concurrent RX and TX handshakes
    fork
      begin
        rx_send(8'h3C, 10, a36);
        check("r36_rx_ack", a36, 1'b1);
      end
      begin
        s_data = 8'hC3; s_valid = 1'b1; step(); s_valid = 1'b0;
        wait_tx_rq(1'b1, 8, "r36_tx_rq");
        check("r36_tx_data", tx_data, 8'hC3);
        tx_st = 1'b1; step(); tx_st = 1'b0;
        wait_tx_rq(1'b0, 4, "r36_tx_release");
      end
    join
    check("r36_m_valid", m_valid, 1'b1);
    check("r36_m_data", m_data, 8'h3C);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("r36_m_empty", m_valid, 1'b0);
    step();

    // randomized traffic against queue models
    rx_phase = 0; rx_wait = 0; st_hold = 0; tx_wd = 0; tx_pulsed = 1'b0;
    prev_tx_rq = tx_rq; prev_tx_data = tx_data;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gen = (cyc < 2500);
      step();
      // FTDI RX emulation
      if (rx_phase == 1 && rx_st === 1'b1) begin
        rx_q.push_back(rx_data);
        rx_rq = 1'b0; rx_phase = 2;
      end else if (rx_phase == 1) begin
        rx_wait++;
        if (rx_wait > 300) begin
          check("rnd_rx_ack_timeout", rx_st, 1'b1);
          rx_rq = 1'b0; rx_phase = 0;
        end
      end else if (rx_phase == 2 && rx_st === 1'b0) begin
        rx_phase = 0;
      end else if (rx_phase == 0 && gen && $urandom_range(0, 2) == 0) begin
        rx_data = 8'($urandom); rx_rq = 1'b1; rx_phase = 1; rx_wait = 0;
      end
      check("rnd_rx_level", rx_level, rx_q.size());
      check("rnd_m_valid", m_valid, rx_q.size() > 0);
      m_ready = gen ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (m_valid && m_ready && rx_q.size() > 0)
        check("rnd_m_data", m_data, rx_q.pop_front());

      // FTDI TX emulation
      if (tx_rq === 1'b1 && prev_tx_rq !== 1'b1) begin
        if (tx_q.size() > 0) check("rnd_tx_data", tx_data, tx_q.pop_front());
        else check("rnd_tx_spurious", tx_rq, 1'b0);
        tx_pulsed = 1'b0; tx_wd = 0;
      end else if (tx_rq === 1'b1) begin
        check("rnd_tx_hold", tx_data, prev_tx_data);
      end
      if (st_hold > 0) begin
        st_hold--;
        if (st_hold == 0) tx_st = 1'b0;
      end else if (tx_rq && !tx_pulsed && $urandom_range(0, 3) == 0) begin
        tx_st = 1'b1; st_hold = $urandom_range(1, 3); tx_pulsed = 1'b1;
      end
      if (tx_rq && tx_pulsed) begin
        tx_wd++;
        if (tx_wd > 12) begin
          check("rnd_tx_release", tx_rq, 1'b0);
          tx_pulsed = 1'b0; tx_wd = 0;
        end
      end
      check("rnd_s_ready", s_ready, tx_q.size() < 16);
      s_valid = gen && ($urandom_range(0, 1) == 1);
      s_data  = 8'($urandom);
      if (s_valid && s_ready) tx_q.push_back(s_data);
      prev_tx_rq = tx_rq; prev_tx_data = tx_data;
    end
    s_valid = 1'b0; tx_st = 1'b0; m_ready = 1'b0; rx_rq = 1'b0;
    repeat (4) step();
    check("rnd_rx_drained", rx_q.size(), 0);
    check("rnd_tx_drained", tx_q.size(), 0);
    check("rnd_rx_level_end", rx_level, 5'd0);

    // reset in the middle of both handshakes
    rx_data = 8'h77; rx_rq = 1'b1;
    s_data = 8'h99; s_valid = 1'b1; step(); s_valid = 1'b0;
    for (int i = 0; i < 10 && !(rx_st === 1'b1 && tx_rq === 1'b1); i++) step();
    check("r37_rx_st_pre", rx_st, 1'b1);
    check("r37_tx_rq_pre", tx_rq, 1'b1);
    reset = 1'b1; rx_rq = 1'b0;
    step();
    check("r37_rx_st", rx_st, 1'b0);
    check("r37_tx_rq", tx_rq, 1'b0);
    check("r37_rx_level", rx_level, 5'd0);
    check("r37_s_ready", s_ready, 1'b1);
    check("r37_m_valid", m_valid, 1'b0);
    reset = 1'b0;
    repeat (6) step();
    check("r37_post_rx_st", rx_st, 1'b0);
    check("r37_post_tx_rq", tx_rq, 1'b0);
    check("r37_post_m_valid", m_valid, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
